// File: rtl/byte_serial_pkg.sv
// Shared types and constants for the byte serial transmitter.
// Frame length depends on BYTE_SERIAL_TX_PARITY_EN (defined: 8E1, undefined: 8N1).
package byte_serial_pkg;

    localparam int DATA_BITS = 8;

`ifdef BYTE_SERIAL_TX_PARITY_EN
    localparam int FRAME_BITS = DATA_BITS + 3;
`else
    localparam int FRAME_BITS = DATA_BITS + 2;
`endif

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } tx_state_t;

    function automatic logic even_parity(input logic [DATA_BITS-1:0] b);
        return ^b;
    endfunction

endpackage

// File: rtl/byte_serial_tx_baud_tick.sv
// Bit-period timer: counts 0..CLK_DIV-1, wraps, and flags the terminal count.
module baud_tick #(
    parameter int CLK_DIV = 868
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    output logic tick
);

    localparam int TW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam logic [TW-1:0] TERM = TW'(CLK_DIV - 1);
    localparam logic [TW-1:0] ONE  = TW'(1);

    logic [TW-1:0] timer_r;

    // Free-running bit timer, restarted from zero when a frame is accepted
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            timer_r <= {TW{1'b0}};
        end else if (clr) begin
            timer_r <= {TW{1'b0}};
        end else if (timer_r == TERM) begin
            timer_r <= {TW{1'b0}};
        end else begin
            timer_r <= timer_r + ONE;
        end
    end

    assign tick = (timer_r == TERM);

endmodule

// File: rtl/byte_serial_tx.sv
// Asynchronous serial transmitter: start bit, 8 data bits LSB-first, optional
// even parity (BYTE_SERIAL_TX_PARITY_EN), stop bit. All outputs are registered.
module byte_serial_tx
    import byte_serial_pkg::*;
#(
    parameter int CLK_DIV = 868
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [7:0] data,
    output logic       tx,
    output logic       busy,
    output logic       done
);

    localparam int IW = $clog2(DATA_BITS);
    localparam logic [IW-1:0] LAST_IDX = IW'(DATA_BITS - 1);
    localparam logic [IW-1:0] IDX_ONE  = IW'(1);

    tx_state_t            state_r;
    logic [DATA_BITS-1:0] shift_r;
    logic [IW-1:0]        index_r;
    logic                 tx_r;
    logic                 busy_r;
    logic                 done_r;
    logic                 tick_s;
    logic                 accept_s;
`ifdef BYTE_SERIAL_TX_PARITY_EN
    logic                 parity_r;
`endif

    assign accept_s = (state_r == IDLE) && start;

    baud_tick #(
        .CLK_DIV (CLK_DIV)
    ) u_baud_tick (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (accept_s),
        .tick  (tick_s)
    );

    // Frame sequencer; tx holds the value for the coming cycle so it never sees inputs combinationally
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r  <= IDLE;
            shift_r  <= {DATA_BITS{1'b0}};
            index_r  <= {IW{1'b0}};
            tx_r     <= 1'b1;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
`ifdef BYTE_SERIAL_TX_PARITY_EN
            parity_r <= 1'b0;
`endif
        end else begin
            done_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (start) begin
                        shift_r  <= data;
                        index_r  <= {IW{1'b0}};
                        state_r  <= START;
                        tx_r     <= 1'b0;
                        busy_r   <= 1'b1;
`ifdef BYTE_SERIAL_TX_PARITY_EN
                        parity_r <= even_parity(data);
`endif
                    end
                end
                START: begin
                    if (tick_s) begin
                        state_r <= DATA;
                        tx_r    <= shift_r[0];
                    end
                end
                DATA: begin
                    if (tick_s) begin
                        if (index_r == LAST_IDX) begin
`ifdef BYTE_SERIAL_TX_PARITY_EN
                            state_r <= PARITY;
                            tx_r    <= parity_r;
`else
                            state_r <= STOP;
                            tx_r    <= 1'b1;
`endif
                        end else begin
                            index_r <= index_r + IDX_ONE;
                            shift_r <= {1'b0, shift_r[DATA_BITS-1:1]};
                            tx_r    <= shift_r[1];
                        end
                    end
                end
`ifdef BYTE_SERIAL_TX_PARITY_EN
                PARITY: begin
                    if (tick_s) begin
                        state_r <= STOP;
                        tx_r    <= 1'b1;
                    end
                end
`endif
                STOP: begin
                    if (tick_s) begin
                        state_r <= IDLE;
                        tx_r    <= 1'b1;
                        busy_r  <= 1'b0;
                        done_r  <= 1'b1;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    tx_r    <= 1'b1;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    assign tx   = tx_r;
    assign busy = busy_r;
    assign done = done_r;

endmodule

// File: tb/tb_byte_serial_tx.sv
// Scoreboard bench for byte_serial_tx at CLK_DIV=4; frames are decoded by a monitor
// and compared against hand-written expected bit patterns.
module tb_byte_serial_tx;

    localparam int D  = 4;
    localparam int FB = byte_serial_pkg::FRAME_BITS;
    localparam int FL = FB * D;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [7:0] data;
    logic       tx;
    logic       busy;
    logic       done;

    byte_serial_tx #(.CLK_DIV(D)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .data  (data),
        .tx    (tx),
        .busy  (busy),
        .done  (done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [7:0]  d;
        logic [10:0] frame;
        int          rise;
        bit          abort;
    } exp_t;

    exp_t sbq[$];
    int   done_at[$];
    int   done_cnt = 0;
    int   total = 0;
    int   bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Transmitted order is bit 0 first: start, d[0]..d[7], [parity], stop
    function automatic logic [10:0] exp_frame(input logic [7:0] d);
`ifdef BYTE_SERIAL_TX_PARITY_EN
        case (d)
            8'hA5:   return 11'b1_0_10100101_0;
            8'h00:   return 11'b1_0_00000000_0;
            8'hFF:   return 11'b1_0_11111111_0;
            8'h5A:   return 11'b1_0_01011010_0;
            8'h07:   return 11'b1_1_00000111_0;
            8'h01:   return 11'b1_1_00000001_0;
            default: return 11'b0_0_00000000_0;
        endcase
`else
        case (d)
            8'hA5:   return 11'b0_1_10100101_0;
            8'h00:   return 11'b0_1_00000000_0;
            8'hFF:   return 11'b0_1_11111111_0;
            8'h5A:   return 11'b0_1_01011010_0;
            8'h07:   return 11'b0_1_00000111_0;
            8'h01:   return 11'b0_1_00000001_0;
            default: return 11'b0_0_00000000_0;
        endcase
`endif
    endfunction

    // Monitor: decode each frame from the busy rise and score it against the queue head
    exp_t        m_e;
    logic [10:0] m_w;
    bit          m_stable;
    bit          m_aborted;
    logic        m_prev_busy = 1'b0;

    initial begin
        forever begin
            @(negedge clk);
            if (rst_n !== 1'b1) begin
                m_prev_busy = 1'b0;
                continue;
            end
            if (busy === 1'b1 && m_prev_busy === 1'b0) begin
                if (sbq.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_frame: got busy rise at cycle %0d want none", cyc);
                    m_prev_busy = 1'b1;
                    continue;
                end
                m_e = sbq.pop_front();
                check("rise_cycle", cyc, m_e.rise);
                m_w       = 11'b0;
                m_stable  = 1'b1;
                m_aborted = 1'b0;
                for (int i = 0; i < FL; i++) begin
                    if (i > 0) begin
                        @(negedge clk);
                        if (rst_n !== 1'b1) begin
                            m_aborted = 1'b1;
                            break;
                        end
                    end
                    if (i % D == 0) m_w[i / D] = tx;
                    else if (tx !== m_w[i / D]) m_stable = 1'b0;
                    if (busy !== 1'b1 || done !== 1'b0) m_stable = 1'b0;
                end
                if (!m_aborted) begin
                    @(negedge clk);
                    if (rst_n !== 1'b1) m_aborted = 1'b1;
                end
                check("abort_state", 32'(m_aborted), 32'(m_e.abort));
                if (!m_aborted) begin
                    check("frame_bits", 32'(m_w), 32'(m_e.frame));
                    check("bit_stable", 32'(m_stable), 32'h1);
                    check("done_cycle", 32'({done, busy, tx}), 32'h5);
                    if (done === 1'b1) begin
                        done_cnt++;
                        done_at.push_back(cyc);
                    end
                end
                m_prev_busy = 1'b0;
            end else begin
                if (busy !== 1'b1) check("idle_line", 32'({done, busy, tx}), 32'h1);
                m_prev_busy = busy;
            end
        end
    end

    task automatic tick_n(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input logic [7:0] d, input int rise, input bit ab);
        exp_t e;
        e.d     = d;
        e.frame = exp_frame(d);
        e.rise  = rise;
        e.abort = ab;
        sbq.push_back(e);
    endtask

    task automatic send(input logic [7:0] d, input bit ab);
        data  = d;
        start = 1'b1;
        push_exp(d, cyc + 1, ab);
        tick_n(1);
        start = 1'b0;
    endtask

    task automatic wait_done(input int target, input int budget);
        int k;
        k = 0;
        while (done_cnt < target && k < budget) begin
            tick_n(1);
            k++;
        end
        if (done_cnt < target) check("done_timeout", done_cnt, target);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish want finish by 100000ns");
        $fatal(1, "watchdog expired");
    end

    int p;

    initial begin
        rst_n = 1'b0;
        start = 1'b1;
        data  = 8'hA5;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("reset_out", 32'({done, busy, tx}), 32'h1);
        end
        @(posedge clk);
        #1;
        start = 1'b0;
        rst_n = 1'b1;
        tick_n(10);
        check("no_frame_after_reset", done_cnt, 0);

        // single frame, done one cycle after the last stop cycle
        p = cyc;
        send(8'hA5, 1'b0);
        wait_done(1, FL + 10);
        check("done_latency_a5", done_at[$] - p, FL + 1);

        // parity-sensitive byte
        tick_n(3);
        p = cyc;
        send(8'h07, 1'b0);
        wait_done(2, FL + 10);
        check("done_latency_07", done_at[$] - p, FL + 1);

        // start and new data mid-frame are ignored
        tick_n(2);
        send(8'hA5, 1'b0);
        tick_n(15);
        data  = 8'h3C;
        start = 1'b1;
        tick_n(1);
        start = 1'b0;
        wait_done(3, FL + 10);
        tick_n(FL + 5);
        check("single_done_collision", done_cnt, 3);

        // start held high: second frame accepted in the done cycle
        tick_n(2);
        p     = cyc;
        data  = 8'h00;
        start = 1'b1;
        push_exp(8'h00, p + 1, 1'b0);
        push_exp(8'hFF, p + FL + 2, 1'b0);
        tick_n(3);
        data = 8'hFF;
        tick_n(FL - 1);
        start = 1'b0;
        wait_done(5, 2 * FL + 20);
        check("b2b_done_spacing", done_at[4] - done_at[3], FL + 1);

        // reset during data bit 3 aborts without done
        tick_n(2);
        send(8'h5A, 1'b1);
        tick_n(4 * D + 1);
        rst_n = 1'b0;
        #1;
        check("async_abort", 32'({done, busy, tx}), 32'h1);
        tick_n(3);
        rst_n = 1'b1;
        tick_n(FL + 5);
        check("no_done_after_abort", done_cnt, 5);
        send(8'h01, 1'b0);
        wait_done(6, FL + 10);

        tick_n(3);
        check("scoreboard_empty", sbq.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
